bcd_updown_counter: RTL

Parameterised multi-digit BCD up/down counter for the parking-lot occupancy display. It consumes the `tick`/`sign` pair produced by the FSM-to-counter adapter: `tick` requests a count step and `sign` selects the direction. It maintains occupancy in packed BCD, flags full and empty, and reports rejected steps so the downstream seven-segment driver and the gate logic can act on them.

---
 rtl/bcd_pkg.sv | 33 +++
 rtl/bcd_digit.sv | 44 ++++
 rtl/bcd_updown_counter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// ============================================================================
// Module : bcd_pkg
// Brief  : Shared BCD digit type, digit limits and the to_bcd elaboration helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
  localparam bcd_digit_t BCD_MIN_DIGIT = 4'd0;
  localparam int         BCD_MAX_DIGITS = 16;

  // Packed BCD image of a non-negative integer, units digit in bits [3:0].
  function automatic logic [4*BCD_MAX_DIGITS-1:0] to_bcd(input int value, input int digits);
    logic [4*BCD_MAX_DIGITS-1:0] img;
    int v;
    img = '0;
    v   = value;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < digits) begin
        img[i*4 +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return img;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// Module : bcd_digit
// Brief  : Combinational single-digit BCD increment/decrement stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t d,
  input  logic       en,
  input  logic       up,
  output bcd_digit_t d_next,
  output logic       carry,
  output logic       borrow
);

  always_comb begin
    d_next = d;
    carry  = 1'b0;
    borrow = 1'b0;
    if (en) begin
      if (up) begin
        if (d >= BCD_MAX_DIGIT) begin
          d_next = BCD_MIN_DIGIT;
          carry  = 1'b1;
        end else begin
          d_next = d + 4'd1;
        end
      end else begin
        if (d == BCD_MIN_DIGIT) begin
          d_next = BCD_MAX_DIGIT;
          borrow = 1'b1;
        end else begin
          d_next = d - 4'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_updown_counter.sv
// ============================================================================
// Module : bcd_updown_counter
// Brief  : Multi-digit BCD up/down occupancy counter with full/empty flags and
//          ovf/unf rejection pulses. BCD_COUNTER_WRAP_EN selects wrap-around
//          on rejected steps; otherwise the count saturates.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int N_DIGITS  = 2,
  parameter int MAX_COUNT = 99
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  tick,
  input  logic                  sign,
  output logic [4*N_DIGITS-1:0] count,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf,
  output logic                  unf
);

  localparam int                      c_w          = 4*N_DIGITS;
  localparam longint                  c_pow        = 64'd10 ** N_DIGITS;
  localparam logic [4*BCD_MAX_DIGITS-1:0] c_max_img = to_bcd(MAX_COUNT, N_DIGITS);
  localparam logic [c_w-1:0]          c_max_bcd    = c_max_img[c_w-1:0];

  if (N_DIGITS < 1 || N_DIGITS > BCD_MAX_DIGITS || MAX_COUNT < 1 ||
      longint'(MAX_COUNT) >= c_pow) begin : g_bad_params
    $error("bcd_updown_counter: MAX_COUNT must lie in 1 .. 10**N_DIGITS-1");
  end

  logic [c_w-1:0]      r_count;
  logic                r_full;
  logic                r_empty;
  logic                r_ovf;
  logic                r_unf;

  logic                w_step;
  logic [N_DIGITS-1:0] w_en;
  logic [N_DIGITS-1:0] w_carry;
  logic [N_DIGITS-1:0] w_borrow;
  logic [c_w-1:0]      w_stepped;
  logic [c_w-1:0]      w_next;
  logic                w_ovf;
  logic                w_unf;
  logic                w_unused_msd_ripple;

  assign w_step = tick & (sign ? ~r_full : ~r_empty);

  // Carry/borrow ripples through every digit in the same cycle.
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digits
    if (i == 0) begin : g_first
      assign w_en[i] = w_step;
    end else begin : g_rest
      assign w_en[i] = w_carry[i-1] | w_borrow[i-1];
    end
    bcd_digit u_digit (
      .d      (r_count[4*i +: 4]),
      .en     (w_en[i]),
      .up     (sign),
      .d_next (w_stepped[4*i +: 4]),
      .carry  (w_carry[i]),
      .borrow (w_borrow[i])
    );
  end

  // The top digit never ripples out: full/empty gating stops it first.
  assign w_unused_msd_ripple = w_carry[N_DIGITS-1] | w_borrow[N_DIGITS-1];

  always_comb begin
    w_next = r_count;
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    if (tick) begin
      if (sign && r_full) begin
        w_ovf = 1'b1;
`ifdef BCD_COUNTER_WRAP_EN
        w_next = '0;
`else
        w_next = r_count;
`endif
      end else if (!sign && r_empty) begin
        w_unf = 1'b1;
`ifdef BCD_COUNTER_WRAP_EN
        w_next = c_max_bcd;
`else
        w_next = r_count;
`endif
      end else begin
        w_next = w_stepped;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_full  <= (w_next == c_max_bcd);
      r_empty <= (w_next == '0);
      r_ovf   <= w_ovf;
      r_unf   <= w_unf;
    end
  end

  assign count = r_count;
  assign full  = r_full;
  assign empty = r_empty;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

`default_nettype wire
